// File: rtl/fir_pkg.sv
// Shared types for the FIR pixel packer: packed output word and lane sizing.
package fir_pkg;

   localparam int unsigned PIX_W        = 8;
   localparam int unsigned PIX_PER_WORD = 4;
   localparam int unsigned LANE_W       = $clog2(PIX_PER_WORD);

   typedef struct packed {
      logic [PIX_PER_WORD*PIX_W-1:0] data;
      logic [PIX_PER_WORD-1:0]       keep;
      logic                          sof;
      logic                          eol;
      logic                          eof;
   } pack_word_t;

endpackage

// File: rtl/sync_fifo.sv
// Type-generic single-clock FIFO with a registered, show-ahead read port.
module sync_fifo #(
   parameter type         T     = logic,
   parameter int unsigned DEPTH = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic push_i,
   input  T     din_i,
   input  logic pop_i,
   output T     dout_o,
   output logic full_o,
   output logic empty_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   T               mem_q [DEPTH];
   T               dout_q;
   logic [AW-1:0]  wr_q;
   logic [AW-1:0]  rd_q;
   logic [AW-1:0]  rd_d;
   logic [AW:0]    cnt_q;
   logic [AW:0]    cnt_d;
   logic           full;
   logic           empty;
   logic           push_en;
   logic           pop_en;
   logic           bypass;

   // Occupancy flags, qualified push/pop and next read pointer.
   always_comb begin
      full    = (cnt_q == (AW+1)'(DEPTH));
      empty   = (cnt_q == '0);
      pop_en  = pop_i & ~empty;
      push_en = push_i & (~full | pop_en);
      rd_d    = rd_q + AW'(pop_en);
      cnt_d   = cnt_q + (AW+1)'(push_en) - (AW+1)'(pop_en);
      // Incoming word becomes the head when nothing older survives this edge.
      bypass  = push_en & (cnt_q == (AW+1)'(pop_en));
   end

   // Storage array write.
   always_ff @(posedge clk) begin
      if (push_en) begin
         mem_q[wr_q] <= din_i;
      end
   end

   // Pointers, count and head-of-queue output register.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q   <= '0;
         rd_q   <= '0;
         cnt_q  <= '0;
         dout_q <= '0;
      end else begin
         if (push_en) begin
            wr_q <= wr_q + AW'(1);
         end
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
         if (bypass) begin
            dout_q <= din_i;
         end else begin
            dout_q <= mem_q[rd_d];
         end
      end
   end

   assign dout_o  = dout_q;
   assign full_o  = full;
   assign empty_o = empty;

endmodule

// File: rtl/fir_pixel_packer.sv
// Tracks frame position of the filtered pixel stream, packs pixels into tagged
// words and buffers them toward the memory-write side.
module fir_pixel_packer
   import fir_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = PIX_W,
   parameter int unsigned PACK_NUM   = PIX_PER_WORD,
   parameter int unsigned SIZE_WIDTH = 12,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           ce_i,
   input  logic                           valid_i,
   input  logic [DATA_WIDTH-1:0]          data_i,
   input  logic [SIZE_WIDTH-1:0]          h_size_i,
   input  logic [SIZE_WIDTH-1:0]          v_size_i,
   input  logic                           ready_i,
   output logic                           valid_o,
   output logic [PACK_NUM*DATA_WIDTH-1:0] data_o,
   output logic [PACK_NUM-1:0]            keep_o,
   output logic                           sof_o,
   output logic                           eol_o,
   output logic                           eof_o,
   output logic                           overflow_o,
   output logic                           frame_done_o
);

   localparam logic [LANE_W-1:0]     LANE_LAST = LANE_W'(PACK_NUM - 1);
   localparam logic [SIZE_WIDTH-1:0] ONE       = SIZE_WIDTH'(1);

   logic [SIZE_WIDTH-1:0]          col_q;
   logic [SIZE_WIDTH-1:0]          row_q;
   logic [SIZE_WIDTH-1:0]          h_q;
   logic [SIZE_WIDTH-1:0]          v_q;
   logic [SIZE_WIDTH-1:0]          h_eff;
   logic [SIZE_WIDTH-1:0]          v_eff;
   logic [LANE_W-1:0]              lane_q;
   logic [PACK_NUM*DATA_WIDTH-1:0] acc_q;
   logic [PACK_NUM*DATA_WIDTH-1:0] acc_d;
   logic [PACK_NUM-1:0]            keep_q;
   logic [PACK_NUM-1:0]            keep_d;
   logic                           sof_q;
   logic                           at_start;
   logic                           accept;
   logic                           last_col;
   logic                           last_row;
   logic                           word_done;
   logic                           pop;
   logic                           fifo_full;
   logic                           fifo_empty;
   logic                           overflow_q;
   logic                           frame_done_q;
   pack_word_t                     word_d;
   pack_word_t                     fifo_dout;

   // Frame position decode and assembly of the word including the current pixel.
   always_comb begin
      at_start  = (col_q == '0) && (row_q == '0);
      // Port sizes are used directly on the first pixel so that pixel is framed
      // against the size it latches.
      h_eff     = at_start ? h_size_i : h_q;
      v_eff     = at_start ? v_size_i : v_q;
      accept    = ce_i & valid_i & (h_eff != '0) & (v_eff != '0);
      last_col  = (col_q == h_eff - ONE);
      last_row  = (row_q == v_eff - ONE);
      word_done = accept & ((lane_q == LANE_LAST) | last_col);

      acc_d = acc_q;
      acc_d[lane_q*DATA_WIDTH +: DATA_WIDTH] = data_i;
      keep_d = keep_q;
      keep_d[lane_q] = 1'b1;

      word_d      = '0;
      word_d.data = acc_d;
      word_d.keep = keep_d;
      word_d.sof  = sof_q | at_start;
      word_d.eol  = last_col;
      word_d.eof  = last_col & last_row;
   end

   assign pop = ~fifo_empty & ready_i;

   sync_fifo #(
      .T     (pack_word_t),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (word_done),
      .din_i   (word_d),
      .pop_i   (pop),
      .dout_o  (fifo_dout),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Position counters, size latch and lane accumulator.
   always_ff @(posedge clk) begin
      if (rst) begin
         col_q  <= '0;
         row_q  <= '0;
         h_q    <= '0;
         v_q    <= '0;
         lane_q <= '0;
         acc_q  <= '0;
         keep_q <= '0;
         sof_q  <= 1'b0;
      end else if (accept) begin
         if (at_start) begin
            h_q <= h_size_i;
            v_q <= v_size_i;
         end
         if (last_col) begin
            col_q <= '0;
            row_q <= last_row ? '0 : row_q + ONE;
         end else begin
            col_q <= col_q + ONE;
         end
         if (word_done) begin
            lane_q <= '0;
            acc_q  <= '0;
            keep_q <= '0;
            sof_q  <= 1'b0;
         end else begin
            lane_q <= lane_q + LANE_W'(1);
            acc_q  <= acc_d;
            keep_q <= keep_d;
            sof_q  <= sof_q | at_start;
         end
      end
   end

   // Sticky drop flag and end-of-frame pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_q   <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         overflow_q   <= overflow_q | (word_done & fifo_full & ~pop);
         frame_done_q <= word_done & word_d.eof;
      end
   end

   assign valid_o      = ~fifo_empty;
   assign data_o       = fifo_dout.data;
   assign keep_o       = fifo_dout.keep;
   assign sof_o        = fifo_dout.sof;
   assign eol_o        = fifo_dout.eol;
   assign eof_o        = fifo_dout.eof;
   assign overflow_o   = overflow_q;
   assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_fir_pixel_packer.sv
// Directed bench for fir_pixel_packer (DATA_WIDTH=8, PACK_NUM=4, FIFO_DEPTH=16).
module tb_fir_pixel_packer;

   logic        clk;
   logic        rst;
   logic        ce_i;
   logic        valid_i;
   logic [7:0]  data_i;
   logic [11:0] h_size_i;
   logic [11:0] v_size_i;
   logic        ready_i;
   logic        valid_o;
   logic [31:0] data_o;
   logic [3:0]  keep_o;
   logic        sof_o;
   logic        eol_o;
   logic        eof_o;
   logic        overflow_o;
   logic        frame_done_o;

   int          total;
   int          bad;
   int          fd_cnt;
   logic [38:0] got_q [$];

   fir_pixel_packer #(
      .DATA_WIDTH (8),
      .PACK_NUM   (4),
      .SIZE_WIDTH (12),
      .FIFO_DEPTH (16)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .ce_i         (ce_i),
      .valid_i      (valid_i),
      .data_i       (data_i),
      .h_size_i     (h_size_i),
      .v_size_i     (v_size_i),
      .ready_i      (ready_i),
      .valid_o      (valid_o),
      .data_o       (data_o),
      .keep_o       (keep_o),
      .sof_o        (sof_o),
      .eol_o        (eol_o),
      .eof_o        (eof_o),
      .overflow_o   (overflow_o),
      .frame_done_o (frame_done_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Record every word that will be popped on the next rising edge.
   always @(negedge clk) begin
      if (valid_o && ready_i) got_q.push_back({data_o, keep_o, sof_o, eol_o, eof_o});
      if (frame_done_o) fd_cnt++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic send_pixel(input logic [7:0] d);
      ce_i    = 1'b1;
      valid_i = 1'b1;
      data_i  = d;
      cyc();
      valid_i = 1'b0;
      data_i  = 8'h00;
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      ce_i    = 1'b0;
      valid_i = 1'b0;
      ready_i = 1'b0;
      cyc();
      cyc();
      rst = 1'b0;
   endtask

   task automatic drain(output logic ok);
      int n;
      n = 0;
      cyc();
      cyc();
      while (valid_o && n < 200) begin
         cyc();
         n++;
      end
      cyc();
      ok = !valid_o;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", valid_o); end
      total++; if (overflow_o !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%b exp=0", overflow_o); end
      total++; if (frame_done_o !== 1'b0) begin bad++; $display("FAIL rst_fd got=%b exp=0", frame_done_o); end
      total++; if (data_o !== 32'h0) begin bad++; $display("FAIL rst_data got=%h exp=0", data_o); end
      total++; if (keep_o !== 4'h0) begin bad++; $display("FAIL rst_keep got=%h exp=0", keep_o); end
      total++; if ({sof_o, eol_o, eof_o} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b exp=000", {sof_o, eol_o, eof_o}); end
   endtask

   task automatic test_frame_8x2();
      logic [38:0] exp_w [4];
      logic [38:0] w;
      logic        ok;
      int          b;
      int          f;
      exp_w[0] = {32'h04030201, 4'hF, 3'b100};
      exp_w[1] = {32'h08070605, 4'hF, 3'b010};
      exp_w[2] = {32'h0C0B0A09, 4'hF, 3'b000};
      exp_w[3] = {32'h100F0E0D, 4'hF, 3'b011};
      b = got_q.size();
      f = fd_cnt;
      h_size_i = 12'd8;
      v_size_i = 12'd2;
      ready_i  = 1'b1;
      for (int i = 1; i <= 16; i++) send_pixel(8'(i));
      drain(ok);
      total++; if (ok !== 1'b1) begin bad++; $display("FAIL f8x2_drain got=busy exp=empty"); end
      total++; if (got_q.size() - b !== 4) begin bad++; $display("FAIL f8x2_count got=%0d exp=4", got_q.size() - b); end
      for (int i = 0; i < 4; i++) begin
         w = (b + i < got_q.size()) ? got_q[b + i] : 'x;
         total++; if (w !== exp_w[i]) begin bad++; $display("FAIL f8x2_word%0d got=%h exp=%h", i, w, exp_w[i]); end
      end
      total++; if (fd_cnt - f !== 1) begin bad++; $display("FAIL f8x2_frame_done got=%0d exp=1", fd_cnt - f); end
   endtask

   task automatic test_partial_line();
      logic [38:0] exp_w [2];
      logic [38:0] w;
      logic        ok;
      int          b;
      int          f;
      exp_w[0] = {32'h04030201, 4'hF, 3'b100};
      exp_w[1] = {32'h00000605, 4'h3, 3'b011};
      b = got_q.size();
      f = fd_cnt;
      h_size_i = 12'd6;
      v_size_i = 12'd1;
      ready_i  = 1'b1;
      for (int i = 1; i <= 6; i++) send_pixel(8'(i));
      drain(ok);
      total++; if (got_q.size() - b !== 2) begin bad++; $display("FAIL part_count got=%0d exp=2", got_q.size() - b); end
      for (int i = 0; i < 2; i++) begin
         w = (b + i < got_q.size()) ? got_q[b + i] : 'x;
         total++; if (w !== exp_w[i]) begin bad++; $display("FAIL part_word%0d got=%h exp=%h", i, w, exp_w[i]); end
      end
      total++; if (fd_cnt - f !== 1) begin bad++; $display("FAIL part_frame_done got=%0d exp=1", fd_cnt - f); end
   endtask

   task automatic test_overflow();
      logic [38:0] w;
      logic        ok;
      int          b;
      do_reset();
      h_size_i = 12'd64;
      v_size_i = 12'd2;
      for (int i = 1; i <= 64; i++) send_pixel(8'(i));
      total++; if (overflow_o !== 1'b0) begin bad++; $display("FAIL ovf_at16 got=%b exp=0", overflow_o); end
      total++; if (valid_o !== 1'b1) begin bad++; $display("FAIL ovf_valid got=%b exp=1", valid_o); end
      for (int i = 65; i <= 68; i++) send_pixel(8'(i));
      total++; if (overflow_o !== 1'b1) begin bad++; $display("FAIL ovf_at17 got=%b exp=1", overflow_o); end
      for (int i = 69; i <= 128; i++) send_pixel(8'(i));
      b = got_q.size();
      ready_i = 1'b1;
      drain(ok);
      total++; if (ok !== 1'b1) begin bad++; $display("FAIL ovf_drain got=busy exp=empty"); end
      total++; if (got_q.size() - b !== 16) begin bad++; $display("FAIL ovf_count got=%0d exp=16", got_q.size() - b); end
      w = (b < got_q.size()) ? got_q[b] : 'x;
      total++; if (w !== {32'h04030201, 4'hF, 3'b100}) begin bad++; $display("FAIL ovf_first got=%h exp=%h", w, {32'h04030201, 4'hF, 3'b100}); end
      w = (b + 15 < got_q.size()) ? got_q[b + 15] : 'x;
      total++; if (w !== {32'h403F3E3D, 4'hF, 3'b010}) begin bad++; $display("FAIL ovf_last got=%h exp=%h", w, {32'h403F3E3D, 4'hF, 3'b010}); end
      total++; if (overflow_o !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow_o); end
   endtask

   task automatic test_full_push_pop();
      logic [38:0] w;
      logic        ok;
      int          b;
      do_reset();
      b = got_q.size();
      h_size_i = 12'd8;
      v_size_i = 12'd8;
      for (int i = 1; i <= 67; i++) send_pixel(8'(i));
      ready_i = 1'b1;
      send_pixel(8'd68);
      ready_i = 1'b0;
      total++; if (overflow_o !== 1'b0) begin bad++; $display("FAIL fpp_ovf got=%b exp=0", overflow_o); end
      ready_i = 1'b1;
      drain(ok);
      total++; if (got_q.size() - b !== 17) begin bad++; $display("FAIL fpp_count got=%0d exp=17", got_q.size() - b); end
      w = (b < got_q.size()) ? got_q[b] : 'x;
      total++; if (w !== {32'h04030201, 4'hF, 3'b100}) begin bad++; $display("FAIL fpp_first got=%h exp=%h", w, {32'h04030201, 4'hF, 3'b100}); end
      w = (b + 16 < got_q.size()) ? got_q[b + 16] : 'x;
      total++; if (w !== {32'h44434241, 4'hF, 3'b100}) begin bad++; $display("FAIL fpp_last got=%h exp=%h", w, {32'h44434241, 4'hF, 3'b100}); end
   endtask

   task automatic test_ce_hold();
      logic [38:0] exp_w [2];
      logic [38:0] w;
      logic        ok;
      int          b;
      exp_w[0] = {32'h04030201, 4'hF, 3'b100};
      exp_w[1] = {32'h08070605, 4'hF, 3'b011};
      do_reset();
      b = got_q.size();
      h_size_i = 12'd8;
      v_size_i = 12'd1;
      ready_i  = 1'b1;
      send_pixel(8'd1);
      send_pixel(8'd2);
      ce_i    = 1'b0;
      valid_i = 1'b1;
      data_i  = 8'hFF;
      repeat (5) cyc();
      valid_i = 1'b0;
      for (int i = 3; i <= 8; i++) send_pixel(8'(i));
      drain(ok);
      total++; if (got_q.size() - b !== 2) begin bad++; $display("FAIL ce_count got=%0d exp=2", got_q.size() - b); end
      for (int i = 0; i < 2; i++) begin
         w = (b + i < got_q.size()) ? got_q[b + i] : 'x;
         total++; if (w !== exp_w[i]) begin bad++; $display("FAIL ce_word%0d got=%h exp=%h", i, w, exp_w[i]); end
      end
   endtask

   task automatic test_rst_mid_frame();
      logic [38:0] w;
      logic        ok;
      int          b;
      do_reset();
      h_size_i = 12'd8;
      v_size_i = 12'd2;
      for (int i = 1; i <= 10; i++) send_pixel(8'(i));
      total++; if (valid_o !== 1'b1) begin bad++; $display("FAIL rstmid_pre_valid got=%b exp=1", valid_o); end
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b exp=0", valid_o); end
      b = got_q.size();
      ready_i = 1'b1;
      for (int i = 8'h21; i <= 8'h24; i++) send_pixel(8'(i));
      drain(ok);
      total++; if (got_q.size() - b !== 1) begin bad++; $display("FAIL rstmid_count got=%0d exp=1", got_q.size() - b); end
      w = (b < got_q.size()) ? got_q[b] : 'x;
      total++; if (w !== {32'h24232221, 4'hF, 3'b100}) begin bad++; $display("FAIL rstmid_word got=%h exp=%h", w, {32'h24232221, 4'hF, 3'b100}); end
   endtask

   initial begin
      total    = 0;
      bad      = 0;
      fd_cnt   = 0;
      rst      = 1'b1;
      ce_i     = 1'b0;
      valid_i  = 1'b0;
      data_i   = 8'h00;
      h_size_i = 12'd0;
      v_size_i = 12'd0;
      ready_i  = 1'b0;
      test_reset();
      test_frame_8x2();
      test_partial_line();
      test_overflow();
      test_full_push_pop();
      test_ce_hold();
      test_rst_mid_frame();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
